instruction_loader: RTL

- Writer side of the instruction-memory load interface of `instruction_fetch`.
- Receives a byte stream (e.g. from the UART receiver) and assembles big-endian 32-bit instruction words.
- Drives `wr_memory_instruction_enable` / `instruction_to_write` / `address_to_write` with auto-incrementing addresses.
- On the EOF word or full memory, stops loading, releases the core via `mips_enable` and pulses a CPU reset so the PC restarts at 0.

---
 rtl/instruction_loader.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/instruction_loader.sv
// Assembles a big-endian byte stream into 32-bit instruction words and writes them
// to instruction memory at auto-incrementing addresses, then releases the core.
module instruction_loader #(
   parameter int                LENGTH    = 32,
   parameter int                MEM_DEPTH = 256,
   parameter logic [LENGTH-1:0] EOF_WORD  = 32'hFFFF_FFFF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_start,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              wr_memory_instruction_enable,
   output logic [LENGTH-1:0] instruction_to_write,
   output logic [LENGTH-1:0] address_to_write,
   output logic              mips_enable,
   output logic              cpu_reset,
   output logic              loading,
   output logic              mem_full,
   output logic [LENGTH-1:0] words_loaded
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RECEIVE = 2'd1,
      WRITE   = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t            state_r, state_s;
   logic [LENGTH-1:0] word_r, word_s, shifted_s;
   logic [1:0]        byte_cnt_r, byte_cnt_s;
   logic [LENGTH-1:0] addr_r, addr_s;
   logic [LENGTH-1:0] words_r, words_s, words_inc_s;
   logic              mem_full_r, mem_full_s;
   logic              wr_en_r, wr_en_s;
   logic [LENGTH-1:0] instr_r, instr_s;
   logic [LENGTH-1:0] wr_addr_r, wr_addr_s;
   logic              mips_en_r, mips_en_s;
   logic              cpu_rst_r, cpu_rst_s;
   logic              loading_r, loading_s;

   // Next-state, datapath and registered-output decode.
   always_comb begin
      state_s     = state_r;
      word_s      = word_r;
      byte_cnt_s  = byte_cnt_r;
      addr_s      = addr_r;
      words_s     = words_r;
      mem_full_s  = mem_full_r;
      wr_en_s     = 1'b0;
      instr_s     = instr_r;
      wr_addr_s   = wr_addr_r;
      shifted_s   = {word_r[LENGTH-9:0], rx_data};
      words_inc_s = words_r + LENGTH'(1);

      if (load_start) begin
         // A new load always wins, even over a byte arriving in the same cycle.
         state_s    = RECEIVE;
         word_s     = '0;
         byte_cnt_s = 2'd0;
         addr_s     = '0;
         words_s    = '0;
         mem_full_s = 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               state_s = IDLE;
            end
            RECEIVE: begin
               if (rx_valid) begin
                  word_s = shifted_s;
                  if (byte_cnt_r == 2'd3) begin
                     byte_cnt_s = 2'd0;
                     state_s    = WRITE;
                     // The strobe is registered here so it is high exactly in the WRITE cycle.
                     if (shifted_s != EOF_WORD) begin
                        wr_en_s   = 1'b1;
                        instr_s   = shifted_s;
                        wr_addr_s = addr_r;
                     end else begin
                        wr_en_s = 1'b0;
                     end
                  end else begin
                     byte_cnt_s = byte_cnt_r + 2'd1;
                  end
               end else begin
                  state_s = RECEIVE;
               end
            end
            WRITE: begin
               if (word_r == EOF_WORD) begin
                  state_s = DONE;
               end else begin
                  addr_s  = addr_r + LENGTH'(4);
                  words_s = words_inc_s;
                  if (words_inc_s == LENGTH'(MEM_DEPTH)) begin
                     mem_full_s = 1'b1;
                     state_s    = DONE;
                  end else begin
                     state_s = RECEIVE;
                     if (rx_valid) begin
                        word_s     = shifted_s;
                        byte_cnt_s = 2'd1;
                     end else begin
                        byte_cnt_s = 2'd0;
                     end
                  end
               end
            end
            DONE: begin
               state_s = DONE;
            end
            default: begin
               state_s = IDLE;
            end
         endcase
      end

      mips_en_s = (state_s == DONE);
      cpu_rst_s = (state_s == DONE) && (state_r != DONE);
      loading_s = (state_s == RECEIVE) || (state_s == WRITE);
   end

   // State and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r    <= IDLE;
         word_r     <= '0;
         byte_cnt_r <= 2'd0;
         addr_r     <= '0;
         words_r    <= '0;
         mem_full_r <= 1'b0;
         wr_en_r    <= 1'b0;
         instr_r    <= '0;
         wr_addr_r  <= '0;
         mips_en_r  <= 1'b0;
         cpu_rst_r  <= 1'b0;
         loading_r  <= 1'b0;
      end else begin
         state_r    <= state_s;
         word_r     <= word_s;
         byte_cnt_r <= byte_cnt_s;
         addr_r     <= addr_s;
         words_r    <= words_s;
         mem_full_r <= mem_full_s;
         wr_en_r    <= wr_en_s;
         instr_r    <= instr_s;
         wr_addr_r  <= wr_addr_s;
         mips_en_r  <= mips_en_s;
         cpu_rst_r  <= cpu_rst_s;
         loading_r  <= loading_s;
      end
   end

   assign wr_memory_instruction_enable = wr_en_r;
   assign instruction_to_write         = instr_r;
   assign address_to_write             = wr_addr_r;
   assign mips_enable                  = mips_en_r;
   assign cpu_reset                    = cpu_rst_r;
   assign loading                      = loading_r;
   assign mem_full                     = mem_full_r;
   assign words_loaded                 = words_r;

endmodule
